spi_slave_responder: RTL

// - Slave end of the SPI link driven by the master's slave-select/SCLK generator; sits in the slave-side SoC on the PCLK domain.
// - Detects SS_n/SCLK edges, shifts MOSI in and MISO out per spi_mode_i/lsbfe_i, double-buffers TX and RX bytes, and flags overrun.

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_sclk_edge_detect.sv | 76 +++++++
 rtl/spi_slave_responder.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave: FSM state encoding, SPI mode codes and
// the byte returned to the master when no TX data has been loaded.
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } spi_state_t;

   // {CPOL,CPHA}
   localparam logic [1:0] MODE0 = 2'b00;
   localparam logic [1:0] MODE1 = 2'b01;
   localparam logic [1:0] MODE2 = 2'b10;
   localparam logic [1:0] MODE3 = 2'b11;

   localparam logic [7:0] TX_IDLE_FILL = 8'hFF;

endpackage

// File: rtl/spi_sclk_edge_detect.sv
// SS/SCLK edge detection for the SPI slave. Build option SPI_SLAVE_INSYNC_EN puts
// ss/sclk/mosi through 2-flop synchronisers first (+2 PCLK latency on every event).
module spi_sclk_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic cpol,
   input  logic cpha,
   input  logic ss_n,
   input  logic sclk,
   input  logic mosi,
   output logic sample_edge,
   output logic shift_edge,
   output logic ss_fall,
   output logic ss_rise,
   output logic ss_low,
   output logic mosi_s
);

   logic ss_d;
   logic sclk_d;
   logic ss_q;
   logic sclk_q;
   logic lead;
   logic trail;

`ifdef SPI_SLAVE_INSYNC_EN
   logic ss_p0, ss_p1, sclk_p0, sclk_p1, mosi_p0, mosi_p1;

   // synchroniser stages p0 -> p1
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ss_p0   <= 1'b1;
         ss_p1   <= 1'b1;
         sclk_p0 <= 1'b0;
         sclk_p1 <= 1'b0;
         mosi_p0 <= 1'b0;
         mosi_p1 <= 1'b0;
      end else begin
         ss_p0   <= ss_n;
         ss_p1   <= ss_p0;
         sclk_p0 <= sclk;
         sclk_p1 <= sclk_p0;
         mosi_p0 <= mosi;
         mosi_p1 <= mosi_p0;
      end
   end

   assign ss_d   = ss_p1;
   assign sclk_d = sclk_p1;
   assign mosi_s = mosi_p1;
`else
   assign ss_d   = ss_n;
   assign sclk_d = sclk;
   assign mosi_s = mosi;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ss_q   <= 1'b1;
         sclk_q <= 1'b0;
      end else begin
         ss_q   <= ss_d;
         sclk_q <= sclk_d;
      end
   end

   // leading edge leaves the CPOL idle level, trailing edge returns to it
   assign lead        = (sclk_d != sclk_q) && (sclk_q == cpol);
   assign trail       = (sclk_d != sclk_q) && (sclk_d == cpol);
   assign sample_edge = cpha ? trail : lead;
   assign shift_edge  = cpha ? lead : trail;
   assign ss_fall     = ss_q & ~ss_d;
   assign ss_rise     = ~ss_q & ss_d;
   assign ss_low      = ~ss_d;

endmodule

// File: rtl/spi_slave_responder.sv
// SPI slave responder: all four SPI modes, MSB/LSB first, double-buffered TX/RX,
// sticky overrun. Build option SPI_SLAVE_INSYNC_EN enables input synchronisers.
module spi_slave_responder
   import spi_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  PCLK,
   input  logic                  PRESET,
   input  logic                  spe_i,
   input  logic [1:0]            spi_mode_i,
   input  logic                  lsbfe_i,
   input  logic                  ss_i,
   input  logic                  sclk_i,
   input  logic                  mosi_i,
   output logic                  miso_o,
   input  logic [DATA_WIDTH-1:0] tx_data_i,
   input  logic                  tx_load_i,
   output logic                  tx_ready_o,
   output logic [DATA_WIDTH-1:0] rx_data_o,
   output logic                  rx_valid_o,
   input  logic                  rx_ack_i,
   output logic                  overrun_o,
   input  logic                  ovr_clr_i,
   output logic                  busy_o
);

   localparam int CW = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0]         LAST_BIT = CW'(DATA_WIDTH - 1);
   localparam logic [DATA_WIDTH-1:0] TX_FILL  = {DATA_WIDTH{TX_IDLE_FILL[0]}};

   spi_state_t            state_q, state_d;
   logic [1:0]            mode_q;
   logic                  lsbfe_q;
   logic [CW-1:0]         count_q;
   logic [DATA_WIDTH-1:0] tx_buf_q, tx_sr_q, rx_sr_q, rx_data_q;
   logic                  tx_full_q, rx_valid_q, overrun_q, miso_q;
   logic                  cpol, cpha;
   logic                  sample_edge, shift_edge, ss_fall, ss_rise, ss_low, mosi_s;
   logic                  load, new_cpha, new_lsb, ovr_set;
   logic [DATA_WIDTH-1:0] tx_src;

   function automatic logic tx_bit(input logic [DATA_WIDTH-1:0] data,
                                   input logic lsb_first, input logic [CW-1:0] idx);
      logic [CW-1:0] ridx;
      ridx = LAST_BIT - idx;
      return lsb_first ? data[idx] : data[ridx];
   endfunction

   assign cpol = (mode_q == MODE2) || (mode_q == MODE3);
   assign cpha = (mode_q == MODE1) || (mode_q == MODE3);

   spi_sclk_edge_detect u_edge (
      .clk         (PCLK),
      .rst         (PRESET),
      .cpol        (cpol),
      .cpha        (cpha),
      .ss_n        (ss_i),
      .sclk        (sclk_i),
      .mosi        (mosi_i),
      .sample_edge (sample_edge),
      .shift_edge  (shift_edge),
      .ss_fall     (ss_fall),
      .ss_rise     (ss_rise),
      .ss_low      (ss_low),
      .mosi_s      (mosi_s)
   );

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (spe_i && ss_fall) state_d = SHIFT;
         SHIFT:   if (!spe_i || ss_rise) state_d = IDLE;
                  else if (sample_edge && count_q == LAST_BIT) state_d = DONE;
         DONE:    state_d = (spe_i && ss_low) ? SHIFT : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // a frame starts either from IDLE or back-to-back out of DONE; both consume the TX buffer
   assign load     = (state_q != SHIFT) && (state_d == SHIFT);
   assign new_cpha = (state_q == IDLE) ? spi_mode_i[0] : mode_q[0];
   assign new_lsb  = (state_q == IDLE) ? lsbfe_i : lsbfe_q;
   assign tx_src   = tx_full_q ? tx_buf_q : TX_FILL;
   assign ovr_set  = (state_q == DONE) && rx_valid_q && !rx_ack_i;

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         mode_q  <= MODE0;
         lsbfe_q <= 1'b0;
         count_q <= '0;
         tx_sr_q <= '0;
         rx_sr_q <= '0;
         miso_q  <= 1'b0;
      end else begin
         if (state_q == IDLE && load) begin
            mode_q  <= spi_mode_i;
            lsbfe_q <= lsbfe_i;
         end
         if (state_d == IDLE) begin
            miso_q <= 1'b0;
         end else if (load) begin
            tx_sr_q <= tx_src;
            rx_sr_q <= '0;
            count_q <= '0;
            if (!new_cpha) miso_q <= tx_bit(tx_src, new_lsb, '0);
         end else if (state_q == SHIFT) begin
            if (sample_edge) begin
               rx_sr_q <= lsbfe_q ? {mosi_s, rx_sr_q[DATA_WIDTH-1:1]}
                                  : {rx_sr_q[DATA_WIDTH-2:0], mosi_s};
               count_q <= count_q + 1'b1;
            end
            // CPHA=0 already drove bit 0 at load; the trailing edge closing the previous frame is ignored
            if (shift_edge && (cpha || count_q != '0))
               miso_q <= tx_bit(tx_sr_q, lsbfe_q, count_q);
         end
      end
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         tx_buf_q  <= '0;
         tx_full_q <= 1'b0;
      end else if (tx_load_i && (!tx_full_q || load)) begin
         tx_buf_q  <= tx_data_i;
         tx_full_q <= 1'b1;
      end else if (load) begin
         tx_full_q <= 1'b0;
      end
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         if (state_q == DONE) begin
            if (!rx_valid_q || rx_ack_i) begin
               rx_data_q  <= rx_sr_q;
               rx_valid_q <= 1'b1;
            end
         end else if (rx_ack_i) begin
            rx_valid_q <= 1'b0;
         end
         if (ovr_set)        overrun_q <= 1'b1;
         else if (ovr_clr_i) overrun_q <= 1'b0;
      end
   end

   assign miso_o     = miso_q;
   assign tx_ready_o = ~tx_full_q;
   assign rx_data_o  = rx_data_q;
   assign rx_valid_o = rx_valid_q;
   assign overrun_o  = overrun_q;
   assign busy_o     = (state_q != IDLE);

endmodule
